// File: rtl/serial_add_ctrl.sv
// Bit-serial wide adder sequencer: feeds one 3-bit slice per clock to an
// external combinational adder_3bit and collects sum and carry, LSB slice first.
module serial_add_ctrl #(
    parameter int unsigned NSLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3*NSLICE-1:0]   op_a,
    input  logic [3*NSLICE-1:0]   op_b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [3*NSLICE-1:0]   result,
    output logic                  cout,
    output logic [2:0]            A,
    output logic [2:0]            B,
    output logic                  Cin,
    input  logic [2:0]            Sum,
    input  logic                  Cout
);

    localparam int unsigned W  = 3 * NSLICE;
    localparam int unsigned IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    result_q;
    logic            carry_q;
    logic            cout_q;
    logic            busy_q;
    logic            done_q;
    logic [IW-1:0]   idx_q;

    // Sequencer: operand capture, per-slice accumulation and the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        carry_q  <= cin;
                        idx_q    <= '0;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < int'(NSLICE); i++) begin
                        if (idx_q == IW'(i)) begin
                            result_q[3*i +: 3] <= Sum;
                        end
                    end
                    carry_q <= Cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= Cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Slice mux toward the adder; quiet outside RUN
    always_comb begin
        A   = 3'b000;
        B   = 3'b000;
        Cin = 1'b0;
        if (state_q == S_RUN) begin
            Cin = carry_q;
            for (int i = 0; i < int'(NSLICE); i++) begin
                if (idx_q == IW'(i)) begin
                    A = a_q[3*i +: 3];
                    B = b_q[3*i +: 3];
                end
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a behavioural adder_3bit and an
// arithmetic reference model of the wide sum and the per-slice carries.
module tb_serial_add_ctrl;

    localparam int unsigned NSLICE = 4;
    localparam int unsigned W      = 3 * NSLICE;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic [2:0]    A;
    logic [2:0]    B;
    logic          Cin;
    logic [2:0]    Sum;
    logic          Cout;

    int n_checks = 0;
    int n_errors = 0;

    serial_add_ctrl #(.NSLICE(NSLICE)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .Sum    (Sum),
        .Cout   (Cout)
    );

    // Behavioural 3-bit adder sitting behind the sequencer
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {3'b000, Cin};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    // Carry entering slice s: overflow of the low 3*s bits of a + b + c
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input int s);
        logic [W:0] m;
        logic [W:0] t;
        m = (W+1)'((64'd1 << (3*s)) - 64'd1);
        t = ({1'b0, a} & m) + ({1'b0, b} & m) + (W+1)'(c);
        return t[3*s];
    endfunction

    // One full operation starting at a negedge in IDLE; hold keeps start high
    // and scrambles the operands while the operation is in flight.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit hold, input string tag);
        logic [W:0] exp_sum;
        exp_sum = ref_sum(a, b, c);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        for (int s = 0; s < int'(NSLICE); s++) begin
            if (hold) begin
                op_a = W'($urandom);
                op_b = W'($urandom);
                cin  = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            check($sformatf("%s.busy%0d", tag, s), 32'(busy), 32'd1);
            check($sformatf("%s.A%0d", tag, s), 32'(A), 32'(a[3*s +: 3]));
            check($sformatf("%s.B%0d", tag, s), 32'(B), 32'(b[3*s +: 3]));
            check($sformatf("%s.Cin%0d", tag, s), 32'(Cin), 32'(carry_into(a, b, c, s)));
            if (s == 0) begin
                check($sformatf("%s.clr", tag), 32'(result), 32'd0);
                check($sformatf("%s.done_early", tag), 32'(done), 32'd0);
            end
            @(negedge clk);
        end
        check($sformatf("%s.done", tag), 32'(done), 32'd1);
        check($sformatf("%s.busy_done", tag), 32'(busy), 32'd0);
        check($sformatf("%s.result", tag), 32'(result), 32'(exp_sum[W-1:0]));
        check($sformatf("%s.cout", tag), 32'(cout), 32'(exp_sum[W]));
        check($sformatf("%s.A_done", tag), 32'(A), 32'd0);
        if (hold) begin
            op_a = W'($urandom);
            op_b = W'($urandom);
        end
        @(negedge clk);
        check($sformatf("%s.done_off", tag), 32'(done), 32'd0);
        check($sformatf("%s.busy_idle", tag), 32'(busy), 32'd0);
        check($sformatf("%s.result_hold", tag), 32'(result), 32'(exp_sum[W-1:0]));
        check($sformatf("%s.cout_hold", tag), 32'(cout), 32'(exp_sum[W]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},   32'(busy),   32'd0);
        check({tag, ".done"},   32'(done),   32'd0);
        check({tag, ".result"}, 32'(result), 32'd0);
        check({tag, ".cout"},   32'(cout),   32'd0);
        check({tag, ".A"},      32'(A),      32'd0);
        check({tag, ".B"},      32'(B),      32'd0);
        check({tag, ".Cin"},    32'(Cin),    32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        run_op(12'h002, 12'h003, 1'b0, 1'b0, "basic");
        run_op(12'hFFF, 12'h001, 1'b0, 1'b0, "chain");
        run_op(12'hFFF, 12'hFFF, 1'b1, 1'b0, "max");
        run_op(12'o5555, 12'o7777, 1'b0, 1'b0, "octal");

        // Start held high: first operands only, re-accepted right after done
        run_op(12'h123, 12'h456, 1'b0, 1'b1, "hold1");
        run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, "hold2");
        run_op(12'h0A5, 12'h35A, 1'b1, 1'b0, "hold3");

        // Reset during the second RUN cycle
        op_a  = 12'hABC;
        op_b  = 12'h987;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        check_all_zero("midrst_hold");
        rst = 1'b0;
        @(negedge clk);
        check("midrst.no_done", 32'(done), 32'd0);
        run_op(12'h001, 12'h001, 1'b0, 1'b0, "after_rst");

        // rst and start together: reset wins
        rst   = 1'b1;
        start = 1'b1;
        op_a  = 12'h111;
        op_b  = 12'h222;
        @(negedge clk);
        check_all_zero("rst_start");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start.idle", 32'(busy), 32'd0);

        for (int k = 0; k < 24; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(3) == 0),
                   $sformatf("rnd%0d", k));
        end
        start = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencing stage wrapped around the combinational `adder_3bit`. Drives its `A`/`B`/`Cin` inputs and consumes its `Sum`/`Cout` outputs.
- Adds two wide operands of 3*NSLICE bits, one 3-bit slice per clock, LSB slice first.
- The carry between slices is held in a flip-flop.
- Start/busy/done handshake toward the control logic upstream.

Parameters:
- NSLICE, 4, number of 3-bit slices. Operand width W = 3*NSLICE. Legal range 1..16.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to add; sampled only in IDLE.
- op_a  input  W  operand A; captured when start is accepted.
- op_b  input  W  operand B; captured when start is accepted.
- cin  input  1  carry-in to slice 0; captured when start is accepted.
- busy  output  1  high while slices are being processed (RUN state).
- done  output  1  one-cycle pulse; result and cout valid from this cycle.
- result  output  W  registered sum.
- cout  output  1  registered carry out of the top slice.
- A  output  3  slice of op_a to adder_3bit.
- B  output  3  slice of op_b to adder_3bit.
- Cin  output  1  carry into adder_3bit.
- Sum  input  3  from adder_3bit; combinational function of A, B, Cin.
- Cout  input  1  from adder_3bit.

Behaviour:
- State machine: IDLE, RUN, DONE. Internal registers:
  - a_q, b_q (W bits each)
  - carry_q (1 bit)
  - idx (ceil(log2(NSLICE)) bits, minimum 1)
- Reset (async, rst=1):
  - state=IDLE.
  - busy=0, done=0, result=0, cout=0.
  - a_q=b_q=0, carry_q=0, idx=0.
  - A=B=0, Cin=0.
- IDLE, start=1 at a clock edge:
  - capture a_q=op_a, b_q=op_b, carry_q=cin.
  - idx=0, result=0, cout=0.
  - go to RUN; busy=1 from the next cycle.
- IDLE, start=0: hold all registers.
- RUN (combinational outputs):
  - A = a_q[3*idx+2 : 3*idx], B = b_q[same slice], Cin = carry_q.
- RUN (each clock edge):
  - result[3*idx+2 : 3*idx] <= Sum.
  - carry_q <= Cout.
  - If idx == NSLICE-1: cout <= Cout, state <= DONE, busy <= 0, done <= 1.
  - Otherwise: idx <= idx+1.
- DONE:
  - Lasts exactly one cycle, then IDLE; done returns to 0.
  - start is ignored during DONE.
- Outputs A, B, Cin are 0 in IDLE and DONE.
- start is ignored in RUN; no queuing, and op_a/op_b changes do not affect the operation in flight.
- Latency: if start is sampled at edge k, done is high for the cycle between edges k+NSLICE and k+NSLICE+1. Throughput is one addition per NSLICE+2 cycles.
- result and cout hold their values after done until the next accepted start clears them.
- Arithmetic: {cout, result} == op_a + op_b + cin, all values unsigned, modulo 2^(W+1), so no overflow is lost.
- Boundary: idx wraps only by returning to IDLE, never mid-RUN. For NSLICE=1, RUN lasts exactly one cycle.
- Reset mid-RUN: abort immediately, no done pulse, all outputs zero. The next start works normally.
- rst and start asserted together: rst wins.

Test Plan:
- NSLICE=4 (W=12). Reset, then op_a=12'h002, op_b=12'h003, cin=0, start pulse:
  - busy high for 4 cycles;
  - slice-0 A=3'b010, B=3'b011;
  - done after 4 cycles with result=12'h005, cout=0.
- Carry chain: op_a=12'hFFF, op_b=12'h001, cin=0:
  - Cin seen by the adder = 0,1,1,1 across the four slices;
  - result=12'h000, cout=1.
- Carry-in and max values: op_a=12'hFFF, op_b=12'hFFF, cin=1 -> result=12'hFFF, cout=1.
- Slice values: op_a=12'o5555, op_b=12'o7777, cin=0:
  - slice 0 drives A=3'b101, B=3'b111, Cin=0;
  - final result=12'o5554, cout=1.
- Handshake: start held high continuously with changing operands:
  - only the first operands are used (12'h123+12'h456 -> 12'h579);
  - start is ignored in RUN and DONE;
  - the next start is accepted in the IDLE cycle after done.
- Reset mid-operation: assert rst during the 2nd RUN cycle:
  - busy/done/result/cout/A/B/Cin become 0 at once, no done pulse;
  - a subsequent 12'h001+12'h001 gives result=12'h002 correctly.
